wt_stream_arbiter: RTL and testbench
====================================

WT_STREAM_ARBITER -- requirements
Module: wt_stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of padded-block requesters sharing one W(t) unit.
REQ-002 Parameter C_S_AXIS_DATA_WIDTH, default 512: block beat width, per requester and output.
REQ-003 Parameter C_AXIS_TUSER_WIDTH, default 128: tuser width, per requester and output.
REQ-004 axis_aclk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  in  NUM_REQ*512  requester i occupies slice [512*i +: 512].
REQ-007 s_axis_tuser  in  NUM_REQ*128  requester i occupies slice [128*i +: 128]; carries multicodec.
REQ-008 s_axis_tvalid / s_axis_tlast  in  NUM_REQ each  per-requester valid and end-of-message.
REQ-009 s_axis_tready  out  NUM_REQ  per-requester ready.
REQ-010 m_axis_tdata / m_axis_tuser / m_axis_tvalid / m_axis_tlast  out  512/128/1/1  stream to the W(t) unit.
REQ-011 m_axis_tready  in  1  downstream ready.
REQ-012 grant_id  out  clog2(NUM_REQ)  index of the locked requester; busy  out  1  high while locked.

Function
REQ-013 Arbitration SHALL be message-granular: once granted, a requester keeps the grant until its tlast beat is accepted.
REQ-014 FSM states: IDLE (no grant), LOCKED (forwarding). IDLE->LOCKED when any s_axis_tvalid is high; LOCKED->IDLE on the cycle the granted tlast beat is accepted.
REQ-015 Grant selection SHALL be round-robin: search starts at last-granted index+1, wrapping modulo NUM_REQ; pointer after reset = 0, so requester 0 wins first.
REQ-016 Grant is registered: valid seen in IDLE at cycle k -> busy=1, grant_id valid, and first beat acceptable at cycle k+1.
REQ-017 s_axis_tready[i] = LOCKED and grant_id==i and (~m_axis_tvalid or m_axis_tready); all other readies 0.
REQ-018 Output SHALL be one register stage: beat accepted at cycle n appears on m_axis_* at cycle n+1; full throughput of one beat/cycle while m_axis_tready=1.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tuser/tlast SHALL hold stable.
REQ-020 Granted requester dropping tvalid mid-message SHALL NOT release the grant; no bubble beats emitted.
REQ-021 Single-beat message (tlast on first beat) SHALL return to IDLE after that beat; next arbitration may occur the following cycle while the output register still holds the beat.
REQ-022 Non-granted requesters' valid changes while LOCKED SHALL have no effect.

Reset
REQ-023 On reset: state=IDLE, RR pointer=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, s_axis_tready=0, grant_id=0, busy=0.
REQ-024 Reset mid-message SHALL discard the partial message and output register content; no beat emitted in the cycle after reset.

Configuration
REQ-025 Macro WT_ARB_ID_TAG_EN: when defined, m_axis_tuser[47:32] (hash tuser slot, offset 32, width 16) SHALL be replaced with grant_id zero-extended; when undefined, tuser passes through unmodified.

Structure
REQ-026 Shared package/header SHALL hold TUSER_SLOT_OFFSET=32, TUSER_SLOT_WIDTH=16, default NUM_REQ, and the IDLE/LOCKED state encoding.
REQ-027 Round-robin priority selection SHALL be a sub-module rr_arbiter (request vector + pointer in, one-hot/index out, combinational).

Verification
REQ-028 Reset, then requester 2 sends 2-beat message (tdata 0xAA.., 0xBB.., tlast on beat 2), m_axis_tready=1 -> busy at k+1, beats out at k+2,k+3, tlast on 0xBB.., IDLE after.
REQ-029 All 4 requesters valid with 1-beat messages continuously -> output grant order 0,1,2,3,0; no requester starved.
REQ-030 Requester 1 locked, m_axis_tready=0 for 5 cycles mid-message -> output beat stable 5 cycles, s_axis_tready[1]=0, no beat lost or duplicated.
REQ-031 Requester 0 drops tvalid 3 cycles mid-message while requester 3 valid -> grant stays 0 until its tlast, then requester 3 granted.
REQ-032 Reset asserted during beat 2 of 4 -> all outputs 0 next cycle, pointer 0, new message from requester 1 forwards cleanly.
REQ-033 With WT_ARB_ID_TAG_EN, requester 3 tuser=0 -> m_axis_tuser[47:32]=16'h0003; without macro -> m_axis_tuser=0.

Source files
------------

// File: rtl/wt_stream_arbiter_pkg.sv
// Shared constants for the W(t) stream arbiter: tuser tag slot, default
// requester count and the IDLE/LOCKED state encoding.
package wt_stream_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ   = 4;
  localparam int TUSER_SLOT_OFFSET = 32;
  localparam int TUSER_SLOT_WIDTH  = 16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_stream_arbiter_rr.sv
// Combinational round-robin selector: the first asserted request at or after
// ptr (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter
  import wt_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  assign any_req = |req;

  // Walk the requests starting at the pointer; the first hit masks the rest.
  always_comb begin
    logic found;
    int   cand;
    logic hit;
    found     = 1'b0;
    cand      = 0;
    hit       = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand           = (int'(ptr) + off) % NUM_REQ;
      hit            = ~found & req[cand];
      grant_oh[cand] = grant_oh[cand] | hit;
      grant_idx      = hit ? IDX_W'(cand) : grant_idx;
      found          = found | hit;
    end
  end

endmodule

// File: rtl/wt_stream_arbiter.sv
// Message-granular round-robin arbiter funnelling padded blocks into one W(t)
// unit. Define WT_ARB_ID_TAG_EN to stamp grant_id into the tuser hash slot.
module wt_stream_arbiter
  import wt_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ             = DEFAULT_NUM_REQ,
  parameter int C_S_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128,
  localparam int IDX_W              = idx_width(NUM_REQ)
) (
  input  logic                                   axis_aclk,
  input  logic                                   reset,
  input  logic [NUM_REQ*C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_REQ-1:0]                     s_axis_tvalid,
  input  logic [NUM_REQ-1:0]                     s_axis_tlast,
  output logic [NUM_REQ-1:0]                     s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]          m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  output logic [IDX_W-1:0]                       grant_id,
  output logic                                   busy
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  logic [0:0]         state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   grant_r;
  logic [NUM_REQ-1:0] grant_oh_r;

  logic [NUM_REQ-1:0] arb_oh_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic               out_free_s;
  logic               accept_s;
  logic [DW-1:0]      sel_data_s;
  logic [UW-1:0]      sel_user_s;
  logic               sel_last_s;
  logic [UW-1:0]      user_s;
  logic [IDX_W-1:0]   ptr_next_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (s_axis_tvalid),
    .ptr       (ptr_r),
    .grant_oh  (arb_oh_s),
    .grant_idx (arb_idx_s),
    .any_req   (arb_any_s)
  );

  assign out_free_s = ~m_axis_tvalid | m_axis_tready;
  assign sel_data_s = s_axis_tdata[int'(grant_r)*DW +: DW];
  assign sel_user_s = s_axis_tuser[int'(grant_r)*UW +: UW];
  assign sel_last_s = s_axis_tlast[grant_r];
  assign accept_s   = |(s_axis_tvalid & s_axis_tready);
  assign ptr_next_s = (arb_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);

  assign busy     = (state_r == ST_LOCKED);
  assign grant_id = grant_r;

  // Only the locked requester may push, and only when the output slot frees up.
  always_comb begin
    if ((state_r == ST_LOCKED) && out_free_s) begin
      s_axis_tready = grant_oh_r;
    end else begin
      s_axis_tready = '0;
    end
  end

  // Optional requester tag in the hash slot; otherwise tuser is untouched.
  always_comb begin
    user_s = sel_user_s;
`ifdef WT_ARB_ID_TAG_EN
    user_s[TUSER_SLOT_OFFSET +: TUSER_SLOT_WIDTH] = TUSER_SLOT_WIDTH'(grant_r);
`endif
  end

  // Grant FSM: lock on a round-robin winner, release when its tlast is taken.
  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      grant_r    <= '0;
      grant_oh_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            state_r    <= ST_LOCKED;
            grant_r    <= arb_idx_s;
            grant_oh_r <= arb_oh_s;
            ptr_r      <= ptr_next_s;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (accept_s && sel_last_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: capture on accept, hold while stalled, drain when taken.
  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_last_s;
      m_axis_tdata  <= sel_data_s;
      m_axis_tuser  <= user_s;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= m_axis_tvalid;
    end
  end

endmodule

// File: tb/tb_wt_stream_arbiter.sv
// Scoreboard bench for wt_stream_arbiter: directed messages are queued per
// requester, expected output beats in hand-derived grant order, and a monitor
// compares every beat the DUT hands off.
module tb_wt_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int UW = 128;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
    int            id;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*UW-1:0]   s_tuser = '0;
  logic [N-1:0]      s_valid = '0;
  logic [N-1:0]      s_last = '0;
  logic [N-1:0]      s_ready;
  logic [DW-1:0]     m_tdata;
  logic [UW-1:0]     m_tuser;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b1;
  logic [1:0]        grant_id;
  logic              busy;

  beat_t rq [N][$];
  beat_t exp_q [$];
  beat_t mon_e;
  logic [N-1:0] hold = '0;
  int vectors = 0;
  int miscompares = 0;

  wt_stream_arbiter #(
    .NUM_REQ(N), .C_S_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axis_aclk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bd(input int id, input int tag, input int b);
    return {16{32'(id * 4096 + tag * 16 + b)}};
  endfunction

  function automatic logic [UW-1:0] bu(input int id, input int b);
    return {4{32'hC0DE_0000 + 32'(id * 256 + b)}};
  endfunction

  function automatic logic [UW-1:0] exp_user(input logic [UW-1:0] u, input int id);
    logic [UW-1:0] r;
    r = u;
`ifdef WT_ARB_ID_TAG_EN
    r[47:32] = 16'(id);
`endif
    return r;
  endfunction

  // Queue a beat on a requester and as the next expected output beat.
  task automatic push(input int id, input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    beat_t b;
    b.d = d; b.u = u; b.l = l; b.id = id;
    rq[id].push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic send(input int id, input int nbeats, input int tag);
    for (int b = 0; b < nbeats; b++) push(id, bd(id, tag, b), bu(id, b), (b == nbeats - 1));
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        s_valid[i] = 1'b1;
        s_tdata[i*DW +: DW] = rq[i][0].d;
        s_tuser[i*UW +: UW] = rq[i][0].u;
        s_last[i] = rq[i][0].l;
      end else begin
        s_valid[i] = 1'b0;
        s_last[i] = 1'b0;
      end
    end
  endtask

  // One clock: note handshakes at the edge, retire them, present next beats.
  task automatic cyc();
    logic [N-1:0] f;
    @(posedge clk);
    f = s_valid & s_ready;
    #1;
    for (int i = 0; i < N; i++) if (f[i]) void'(rq[i].pop_front());
    present();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold = '0;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    present();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cyc();
      done = (exp_q.size() == 0) && !busy && (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding", name, budget, exp_q.size());
    end
  endtask

  task automatic wait_beat(input string name, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cyc();
      seen = m_valid && (m_tdata == d);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: beat %0h never reached the output", name, d);
    end
  endtask

  // Scoreboard monitor: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got %0h expected no beat", m_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", m_tdata, mon_e.d);
        chk("beat_user", DW'(m_tuser), DW'(exp_user(mon_e.u, mon_e.id)));
        chk("beat_last", DW'(m_last), DW'(mon_e.l));
      end
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_m_valid", DW'(m_valid), '0);
    chk("rst_m_last", DW'(m_last), '0);
    chk("rst_m_data", m_tdata, '0);
    chk("rst_m_user", DW'(m_tuser), '0);
    chk("rst_s_ready", DW'(s_ready), '0);
    chk("rst_grant_id", DW'(grant_id), '0);
    chk("rst_busy", DW'(busy), '0);

    // Requester 2, two beats: busy at k+1, beats at k+2/k+3, idle after tlast.
    push(2, {64{8'hAA}}, bu(2, 0), 1'b0);
    push(2, {64{8'hBB}}, bu(2, 1), 1'b1);
    present();
    cyc();
    @(negedge clk);
    chk("s1_busy", DW'(busy), DW'(1'b1));
    chk("s1_grant_id", DW'(grant_id), DW'(2'd2));
    chk("s1_s_ready", DW'(s_ready), DW'(4'b0100));
    chk("s1_no_early_beat", DW'(m_valid), '0);
    cyc();
    @(negedge clk);
    chk("s1_beat1_valid", DW'(m_valid), DW'(1'b1));
    chk("s1_beat1_data", m_tdata, {64{8'hAA}});
    cyc();
    @(negedge clk);
    chk("s1_beat2_data", m_tdata, {64{8'hBB}});
    chk("s1_beat2_last", DW'(m_last), DW'(1'b1));
    chk("s1_idle", DW'(busy), '0);
    cyc();
    @(negedge clk);
    chk("s1_drained", DW'(m_valid), '0);

    // All four requesters with back-to-back 1-beat messages: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) send(i, 1, r + 1);
    present();
    wait_idle("rr_order", 80);

    // Requester 1 locked, downstream stalls 5 cycles while beat 2 is on the output.
    send(1, 4, 3);
    present();
    wait_beat("stall_sync", bd(1, 3, 1));
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_data", m_tdata, bd(1, 3, 1));
      chk("stall_valid", DW'(m_valid), DW'(1'b1));
      chk("stall_s_ready", DW'(s_ready[1]), '0);
      cyc();
    end
    m_ready = 1'b1;
    wait_idle("stall_drain", 40);

    // Requester 0 pauses mid-message while 3 waits; 0 keeps the grant.
    send(0, 4, 4);
    present();
    cyc();
    cyc();
    send(3, 1, 4);
    hold[0] = 1'b1;
    present();
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clk);
      chk("pause_grant", DW'(grant_id), '0);
      chk("pause_busy", DW'(busy), DW'(1'b1));
    end
    hold[0] = 1'b0;
    present();
    wait_idle("pause_drain", 40);
    chk("pause_next_grant", DW'(grant_id), DW'(2'd3));

    // Reset during beat 2 of 4; then 1 and 3 contend and 1 must win from pointer 0.
    send(2, 4, 5);
    present();
    wait_beat("rst_sync", bd(2, 5, 1));
    reset = 1'b1;
    rq[2].delete();
    exp_q.delete();
    present();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", DW'(m_valid), '0);
    chk("mid_rst_last", DW'(m_last), '0);
    chk("mid_rst_data", m_tdata, '0);
    chk("mid_rst_user", DW'(m_tuser), '0);
    chk("mid_rst_busy", DW'(busy), '0);
    chk("mid_rst_grant", DW'(grant_id), '0);
    send(1, 2, 6);
    send(3, 1, 6);
    present();
    cyc();
    @(negedge clk);
    chk("post_rst_grant", DW'(grant_id), DW'(2'd1));
    wait_idle("post_rst_drain", 40);

    // Requester 3 with zero tuser: slot carries 3 only when tagging is built in.
    do_reset();
    push(3, bd(3, 7, 0), '0, 1'b1);
    present();
    wait_beat("tag_sync", bd(3, 7, 0));
`ifdef WT_ARB_ID_TAG_EN
    chk("tag_slot", DW'(m_tuser), DW'(128'h0000_0000_0000_0003_0000_0000));
`else
    chk("tag_slot", DW'(m_tuser), '0);
`endif
    wait_idle("tag_drain", 20);

    chk("leftover_expected", DW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
